// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed restoring divider controller: IDLE -> LOAD -> ITER x WIDTH -> FIX.
// Optional macro DIV_EARLY_EXIT_EN skips the iteration when |b| = 0 or |a| < |b|.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;       // dividend, then |a|, then shifting quotient
  logic [WIDTH-1:0]   b_q, b_d;       // divisor, then |b|
  logic [WIDTH-1:0]   p_q, p_d;       // partial remainder
  logic [WIDTH-1:0]   dvd_q, dvd_d;   // original dividend for the divide-by-zero remainder
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     p_ext;
  logic               p_ge;

  assign a_mag = sa_q ? (~a_q + 1'b1) : a_q;
  assign b_mag = sb_q ? (~b_q + 1'b1) : b_q;
  // One extra bit so P' >= |b| cannot overflow when |b| = 2^(WIDTH-1)
  assign p_ext = {p_q, a_q[WIDTH-1]};
  assign p_ge  = p_ext >= {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    dvd_d   = dvd_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = dividend;
        b_d     = divisor;
        dvd_d   = dividend;
        sa_d    = dividend[WIDTH-1];
        sb_d    = divisor[WIDTH-1];
        quo_d   = '0;
        rem_d   = '0;
        dz_d    = 1'b0;
        state_d = LOAD;
      end
      LOAD: begin
        a_d     = a_mag;
        b_d     = b_mag;
        p_d     = '0;
        cnt_d   = '0;
        state_d = ITER;
`ifdef DIV_EARLY_EXIT_EN
        if (b_mag == '0 || a_mag < b_mag) begin
          a_d     = '0;
          p_d     = a_mag;
          state_d = FIX;
        end
`endif
      end
      ITER: begin
        p_d   = p_ge ? (p_ext[WIDTH-1:0] - b_q) : p_ext[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], p_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        // Here b_q holds |b|, so zero means the divisor was zero
        if (b_q == '0) begin
          quo_d = '1;
          rem_d = dvd_q;
          dz_d  = 1'b1;
        end else begin
          quo_d = (sa_q ^ sb_q) ? (~a_q + 1'b1) : a_q;
          rem_d = sa_q ? (~p_q + 1'b1) : p_q;
          dz_d  = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d  = (state_q == FIX);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      dvd_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      dvd_q   <= dvd_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed and random checks of div_seq_ctrl: signs, divide-by-zero, overflow, latency, abort, back-to-back.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        clr, start;
  logic [31:0] dividend, divisor;
  logic        ready, done, div_zero;
  logic [31:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start),
    .dividend(dividend), .divisor(divisor),
    .ready(ready), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_EXIT_EN
    logic [31:0] ma, mb;
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    if (mb == 32'd0 || ma < mb) return 2;
`endif
    return 34;
  endfunction

  // Called at a negedge; leaves at the negedge of the done cycle so a following call is back-to-back.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez,
                        input int glitch);
    int  lat;
    bit  rdy_err;
    lat = 0;
    rdy_err = 0;
    chk({tag, "_rdy_pre"}, 32'(ready), 32'd1);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dividend = 32'hDEADBEEF; divisor = 32'h12345678;
    while (!done && lat < 40) begin
      if (ready) rdy_err = 1;
      if (glitch != 0 && lat == glitch) begin
        start = 1'b1; dividend = 32'd999; divisor = 32'd3;
      end else
        start = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) begin
      chk({tag, "_timeout"}, 32'(lat), 32'(exp_lat(a, b)));
      return;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(a, b)));
    chk({tag, "_rdy_busy"}, 32'(rdy_err), 32'd0);
    chk({tag, "_rdy_done"}, 32'(ready), 32'd1);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, 32'(div_zero), 32'(ez));
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic        ez;
    clr = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    clr = 1'b0;
    @(negedge clk);

    do_div("p100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
    @(negedge clk);
    chk("pulse_one", 32'(done), 32'd0);
    chk("hold_q", quotient, 32'd14);
    chk("hold_r", remainder, 32'd2);

    do_div("n100_7",  -32'sd100, 32'd7,     -32'sd14, -32'sd2, 1'b0, 0);
    do_div("p100_n7", 32'd100,   -32'sd7,   -32'sd14, 32'd2,   1'b0, 0);
    do_div("n100_n7", -32'sd100, -32'sd7,   32'd14,   -32'sd2, 1'b0, 0);
    do_div("div0",    32'd7,     32'd0,     32'hFFFFFFFF, 32'd7, 1'b1, 0);
    do_div("ndiv0",   -32'sd7,   32'd0,     32'hFFFFFFFF, -32'sd7, 1'b1, 0);
    do_div("ovf",     32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 0);
    do_div("small",   32'd3,     32'd100,   32'd0,    32'd3,   1'b0, 0);
    do_div("mnmin",   32'h80000000, 32'd7,  32'hEDB6DB6E, 32'hFFFFFFFE, 1'b0, 0);

    // Start while busy is ignored; start in the done cycle is taken
    do_div("ign", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 5);
    do_div("b2b", 32'd50,   32'd5,  32'd10,  32'd0, 1'b0, 0);

    // Abort after ten iteration steps
    @(negedge clk);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(ready), 32'd0);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    chk("abort_dz", 32'(div_zero), 32'd0);
    clr = 1'b0;
    @(negedge clk);
    do_div("post_abort", 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 0);

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(0, 20) - 10;
        2: b = {{16{a[5]}}, 16'($urandom)};
        default: b = $urandom_range(1, 1000);
      endcase
      if (i == 7) a = 32'h80000000;
      if (b == 32'd0) begin
        eq = 32'hFFFFFFFF; er = a; ez = 1'b1;
      end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        eq = 32'h80000000; er = 32'd0; ez = 1'b0;
      end else begin
        eq = $signed(a) / $signed(b);
        er = $signed(a) % $signed(b);
        ez = 1'b0;
      end
      do_div("rnd", a, b, eq, er, ez, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
